img_binary_adaptive: RTL and testbench

Parametrised next-generation binarisation stage for the YUV pixel stream between colour conversion and the Ethernet packer. It thresholds the Y channel in one of four modes: fixed, adaptive, band or inverted. In adaptive mode the threshold is the mean luminance of the previous frame plus a signed offset. The mean is computed by a sequential divider that runs during vertical blanking.

---
 rtl/img_pkg.sv | 21 ++
 rtl/seq_divider.sv | 63 ++++++
 rtl/img_binary_adaptive.sv | 213 +++++++++++++++++++++
 tb/tb_img_binary_adaptive.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared types for the luminance binarisation stage.
package img_pkg;

    typedef enum logic [1:0] {
        MODE_FIXED = 2'd0,
        MODE_ADAPT = 2'd1,
        MODE_BAND  = 2'd2,
        MODE_INV   = 2'd3
    } img_mode_e;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        UPDATE
    } bin_state_e;

    function automatic int img_data_w(input int pix_w);
        return 3 * pix_w;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, N_W cycles per run.
module seq_divider #(
    parameter int N_W = 28,
    parameter int D_W = 20
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           abort,
    input  logic [N_W-1:0] dividend,
    input  logic [D_W-1:0] divisor,
    output logic           busy,
    output logic           done,
    output logic [N_W-1:0] quotient
);

    localparam int SW = $clog2(N_W + 1);

    logic [D_W-1:0] rem;
    logic [D_W-1:0] dvs;
    logic [N_W-1:0] quo;
    logic [SW-1:0]  step;
    logic [D_W:0]   shifted;
    logic [D_W:0]   diff;
    logic           ge;

    assign shifted  = {rem, quo[N_W-1]};
    assign ge       = shifted >= {1'b0, dvs};
    assign diff     = shifted - {1'b0, dvs};
    assign quotient = quo;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem  <= '0;
            dvs  <= '0;
            quo  <= '0;
            step <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else if (start) begin
            rem  <= '0;
            dvs  <= divisor;
            quo  <= dividend;
            step <= '0;
            busy <= 1'b1;
            done <= 1'b0;
        end else if (abort) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else if (busy) begin
            rem  <= ge ? diff[D_W-1:0] : shifted[D_W-1:0];
            quo  <= {quo[N_W-2:0], ge};
            step <= step + 1'b1;
            if (step == SW'(N_W - 1)) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/img_binary_adaptive.sv
// Y-channel binariser: fixed, adaptive (previous-frame mean), band, inverted.
// Optional hysteresis on modes 0/1/3 with IMG_BIN_HYST_EN.
module img_binary_adaptive
    import img_pkg::*;
#(
    parameter int PIX_W       = 8,
    parameter int MAX_PIXELS  = 921600,
    parameter int THRESH_INIT = 127,
    parameter int HYST        = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         frame_start_i,
    input  logic [img_data_w(PIX_W)-1:0] img_data_i,
    input  logic                         valid_i,
    input  logic [1:0]                   cfg_mode,
    input  logic [PIX_W-1:0]             cfg_thresh,
    input  logic [PIX_W-1:0]             cfg_thresh_hi,
    input  logic [PIX_W:0]               cfg_offset,
    output logic [img_data_w(PIX_W)-1:0] img_data_o,
    output logic                         valid_o,
    output logic [PIX_W-1:0]             thresh_o,
    output logic                         busy_o
);

    localparam int DW    = img_data_w(PIX_W);
    localparam int CNT_W = $clog2(MAX_PIXELS + 1);
    localparam int SUM_W = PIX_W + CNT_W;
    localparam int EXT   = SUM_W + 2;
    localparam logic [PIX_W-1:0] PIX_MAX = '1;
`ifdef IMG_BIN_HYST_EN
    localparam bit HYST_ON = 1'b1;
`else
    localparam bit HYST_ON = 1'b0;
`endif

    logic [PIX_W-1:0] y;
    logic             unused_uv;
    logic [PIX_W-1:0] adapt_thr;
    logic [PIX_W-1:0] sel_thr;

    assign y         = img_data_i[DW-1 -: PIX_W];
    assign unused_uv = ^img_data_i[DW-PIX_W-1:0];
    assign thresh_o  = adapt_thr;

    always_comb begin
        sel_thr = cfg_thresh;
        if (img_mode_e'(cfg_mode) == MODE_ADAPT)
            sel_thr = adapt_thr;
    end

    logic             s1_valid;
    logic [PIX_W-1:0] s1_y;
    img_mode_e        s1_mode;
    logic [PIX_W-1:0] s1_thr;
    logic [PIX_W-1:0] s1_hi;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_y     <= '0;
            s1_mode  <= MODE_FIXED;
            s1_thr   <= '0;
            s1_hi    <= '0;
        end else begin
            s1_valid <= valid_i;
            if (valid_i) begin
                s1_y    <= y;
                s1_mode <= img_mode_e'(cfg_mode);
                s1_thr  <= sel_thr;
                s1_hi   <= cfg_thresh_hi;
            end
        end
    end

    logic             prev_bin;
    logic [PIX_W:0]   thr_up;
    logic [PIX_W-1:0] thr_hi;
    logic [PIX_W-1:0] thr_lo;
    logic [PIX_W-1:0] thr_eff;
    logic             bin;

    assign thr_up = {1'b0, s1_thr} + (PIX_W+1)'(HYST);
    assign thr_hi = (thr_up > {1'b0, PIX_MAX}) ? PIX_MAX
                                                : thr_up[PIX_W-1:0];
    assign thr_lo = (s1_thr < PIX_W'(HYST)) ? '0
                                             : s1_thr - PIX_W'(HYST);

    always_comb begin
        thr_eff = s1_thr;
        if (HYST_ON)
            thr_eff = prev_bin ? thr_lo : thr_hi;
    end

    always_comb begin
        bin = 1'b0;
        unique case (s1_mode)
            MODE_FIXED,
            MODE_ADAPT: bin = s1_y > thr_eff;
            MODE_BAND:  bin = (s1_thr < s1_hi) && (s1_y > s1_thr)
                              && (s1_y <= s1_hi);
            MODE_INV:   bin = s1_y <= thr_eff;
            default:    bin = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_o    <= 1'b0;
            img_data_o <= '0;
        end else begin
            valid_o <= s1_valid;
            if (s1_valid)
                img_data_o <= {DW{bin}};
        end
    end

    // A new frame forgets the last decision so hysteresis starts low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            prev_bin <= 1'b0;
        else if (frame_start_i)
            prev_bin <= 1'b0;
        else if (s1_valid)
            prev_bin <= bin;
    end

    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum <= '0;
            cnt <= '0;
        end else if (frame_start_i) begin
            sum <= '0;
            cnt <= '0;
        end else if (valid_i && (cnt != CNT_W'(MAX_PIXELS))) begin
            sum <= sum + SUM_W'(y);
            cnt <= cnt + 1'b1;
        end
    end

    bin_state_e       state;
    logic             div_start;
    logic             div_abort;
    logic             div_busy;
    logic             div_done;
    logic [SUM_W-1:0] div_q;

    assign div_start = frame_start_i && (cnt != '0);
    assign div_abort = frame_start_i && (state != IDLE);
    assign busy_o    = div_busy;

    seq_divider #(
        .N_W(SUM_W),
        .D_W(CNT_W)
    ) u_div (
        .clk     (clk),
        .reset   (reset),
        .start   (div_start),
        .abort   (div_abort),
        .dividend(sum),
        .divisor (cnt),
        .busy    (div_busy),
        .done    (div_done),
        .quotient(div_q)
    );

    logic signed [EXT-1:0] thr_sum;
    logic [PIX_W-1:0]      thr_clamp;

    assign thr_sum = $signed({2'b00, div_q})
                   + $signed({{(EXT-PIX_W-1){cfg_offset[PIX_W]}}, cfg_offset});

    always_comb begin
        thr_clamp = thr_sum[PIX_W-1:0];
        if (thr_sum[EXT-1])
            thr_clamp = '0;
        else if (|thr_sum[EXT-2:PIX_W])
            thr_clamp = PIX_MAX;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            adapt_thr <= PIX_W'(THRESH_INIT);
        end else begin
            unique case (state)
                IDLE: begin
                    if (div_start)
                        state <= DIVIDE;
                end
                DIVIDE: begin
                    if (frame_start_i)
                        state <= div_start ? DIVIDE : IDLE;
                    else if (div_done)
                        state <= UPDATE;
                end
                UPDATE: begin
                    if (frame_start_i) begin
                        state <= div_start ? DIVIDE : IDLE;
                    end else begin
                        adapt_thr <= thr_clamp;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_img_binary_adaptive.sv
// Directed bench for img_binary_adaptive with a queued scoreboard.
module tb_img_binary_adaptive;

    localparam int PIX_W = 8;
    localparam int SUM_W = 28;

    logic        clk;
    logic        reset;
    logic        frame_start_i;
    logic [23:0] img_data_i;
    logic        valid_i;
    logic [1:0]  cfg_mode;
    logic [7:0]  cfg_thresh;
    logic [7:0]  cfg_thresh_hi;
    logic [8:0]  cfg_offset;
    logic [23:0] img_data_o;
    logic        valid_o;
    logic [7:0]  thresh_o;
    logic        busy_o;

    img_binary_adaptive dut (
        .clk          (clk),
        .reset        (reset),
        .frame_start_i(frame_start_i),
        .img_data_i   (img_data_i),
        .valid_i      (valid_i),
        .cfg_mode     (cfg_mode),
        .cfg_thresh   (cfg_thresh),
        .cfg_thresh_hi(cfg_thresh_hi),
        .cfg_offset   (cfg_offset),
        .img_data_o   (img_data_o),
        .valid_o      (valid_o),
        .thresh_o     (thresh_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [23:0] data;
        int          due;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0 && valid_o === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid actual %0h required none",
                         img_data_o);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pixel", {8'h0, img_data_o}, {8'h0, e.data});
                chk("latency", cyc, e.due);
            end
        end
    end

    task automatic send(input logic [7:0] y, input logic [23:0] exp);
        exp_t e;
        @(negedge clk);
        valid_i    = 1'b1;
        img_data_i = {y, 8'h40, 8'hC0};
        e.data     = exp;
        e.due      = cyc + 2;
        q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic fs();
        @(negedge clk);
        valid_i       = 1'b0;
        frame_start_i = 1'b1;
        @(negedge clk);
        frame_start_i = 1'b0;
    endtask

    task automatic wait_div(output int nbusy);
        bit seen;
        nbusy = 0;
        seen  = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (busy_o) begin
                nbusy++;
                seen = 1'b1;
            end else if (seen) begin
                break;
            end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 50; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain", q.size(), 0);
    endtask

    localparam logic [23:0] ONE  = 24'hFFFFFF;
    localparam logic [23:0] ZERO = 24'h000000;

    int nb;
    int hits;

    initial begin
        reset         = 1'b1;
        frame_start_i = 1'b0;
        img_data_i    = '0;
        valid_i       = 1'b0;
        cfg_mode      = 2'd0;
        cfg_thresh    = 8'd127;
        cfg_thresh_hi = 8'd0;
        cfg_offset    = 9'd0;
        repeat (3) @(negedge clk);
        chk("rst_valid", valid_o, 0);
        chk("rst_data", img_data_o, 0);
        chk("rst_thresh", thresh_o, 127);
        chk("rst_busy", busy_o, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

`ifdef IMG_BIN_HYST_EN
        fs();
        send(8'd130, ZERO);
        send(8'd125, ZERO);
        send(8'd122, ZERO);
        send(8'd132, ONE);
        send(8'd124, ONE);
        idle();
        drain();
`else
        // fixed mode with bubbles between pixels
        send(8'd127, ZERO);
        idle();
        send(8'd128, ONE);
        send(8'd0, ZERO);
        idle();
        idle();
        send(8'd255, ONE);
        idle();
        drain();
        chk("hold_valid", valid_o, 0);
        chk("hold_data", img_data_o, ONE);

        fs();
        wait_div(nb);
        chk("thr_mean127", thresh_o, 127);

        send(8'd10, ZERO);
        send(8'd20, ZERO);
        send(8'd30, ZERO);
        send(8'd40, ZERO);
        idle();
        drain();
        fs();
        wait_div(nb);
        chk("busy_cycles", nb, SUM_W);
        chk("thr_mean25", thresh_o, 25);

        cfg_mode = 2'd1;
        send(8'd25, ZERO);
        send(8'd26, ONE);
        idle();
        drain();

        cfg_mode = 2'd0;
        fs();
        wait_div(nb);
        send(8'd250, ONE);
        send(8'd250, ONE);
        idle();
        drain();
        cfg_offset = 9'd20;
        fs();
        wait_div(nb);
        chk("thr_clamp_hi", thresh_o, 255);

        send(8'd5, ZERO);
        send(8'd5, ZERO);
        idle();
        drain();
        cfg_offset = 9'h1EC;
        fs();
        wait_div(nb);
        chk("thr_clamp_lo", thresh_o, 0);

        fs();
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy_o) nb++;
            @(negedge clk);
        end
        chk("empty_busy", nb, 0);
        chk("empty_thr", thresh_o, 0);

        cfg_offset = 9'd0;
        send(8'd100, ZERO);
        send(8'd100, ZERO);
        idle();
        fs();
        repeat (5) @(negedge clk);
        send(8'd200, ONE);
        send(8'd200, ONE);
        idle();
        fs();
        hits = 0;
        for (int i = 0; i < 80; i++) begin
            if (thresh_o == 8'd100) hits++;
            @(negedge clk);
        end
        chk("abort_no_stale", hits, 0);
        chk("abort_thr", thresh_o, 200);
        drain();

        cfg_mode      = 2'd2;
        cfg_thresh    = 8'd50;
        cfg_thresh_hi = 8'd100;
        send(8'd50, ZERO);
        send(8'd51, ONE);
        send(8'd100, ONE);
        send(8'd101, ZERO);
        idle();
        drain();
        cfg_thresh    = 8'd100;
        cfg_thresh_hi = 8'd50;
        send(8'd50, ZERO);
        send(8'd75, ZERO);
        send(8'd101, ZERO);
        send(8'd255, ZERO);
        idle();
        drain();

        cfg_mode   = 2'd3;
        cfg_thresh = 8'd127;
        send(8'd127, ONE);
        send(8'd128, ZERO);
        idle();
        drain();

        // threshold change between two back-to-back pixels
        cfg_mode = 2'd0;
        send(8'd128, ONE);
        begin
            exp_t e;
            @(negedge clk);
            cfg_thresh = 8'd200;
            valid_i    = 1'b1;
            img_data_i = {8'd128, 8'h40, 8'hC0};
            e.data     = ZERO;
            e.due      = cyc + 2;
            q.push_back(e);
        end
        idle();
        drain();
`endif

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
